// File: rtl/adaptive_threshold.sv
// Adaptive threshold stage: streams every pixel address once, compares each
// original pixel with (local mean - OFFSET) and writes a binary 0/255 image.
// One pixel per clock; a two-stage pipeline follows the 1-cycle memory latency.
module adaptive_threshold #(
  parameter int WIDTH_BITS  = 7,
  parameter int HEIGHT_BITS = 7,
  parameter int WIDTH       = 2 ** WIDTH_BITS,
  parameter int HEIGHT      = 2 ** HEIGHT_BITS,
  parameter int OFFSET      = 8,
  parameter int INVERT      = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  output logic [WIDTH_BITS-1:0]            oReadCol,
  output logic [HEIGHT_BITS-1:0]           oReadRow,
  input  logic [7:0]                       iImageData,
  input  logic [7:0]                       iMeanData,
  output logic [WIDTH_BITS-1:0]            oResultCol,
  output logic [HEIGHT_BITS-1:0]           oResultRow,
  output logic [7:0]                       oResultData,
  output logic                             oResultWren,
  output logic [WIDTH_BITS+HEIGHT_BITS:0]  oForegroundCount,
  output logic                             busy,
  output logic                             finished
);

  localparam int DATA_W = 8;
  localparam int CMP_W  = DATA_W + 2;
  localparam int PW     = WIDTH_BITS + HEIGHT_BITS;
  localparam int CNT_W  = PW + 1;

  localparam logic [CNT_W-1:0]        N_CNT    = CNT_W'(WIDTH * HEIGHT);
  localparam logic [PW-1:0]           LAST_POS = PW'(WIDTH * HEIGHT - 1);
  localparam logic signed [CMP_W-1:0] OFFSET_S = CMP_W'(OFFSET);
  localparam logic                    INV_B    = (INVERT != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Foreground test in signed arithmetic so a mean below OFFSET gives a
  // negative threshold instead of wrapping to a large unsigned value.
  function automatic logic is_fg(input logic [DATA_W-1:0] img,
                                 input logic [DATA_W-1:0] mean);
    logic signed [CMP_W-1:0] pix_s;
    logic signed [CMP_W-1:0] thr_s;
    pix_s = $signed({2'b00, img});
    thr_s = $signed({2'b00, mean}) - OFFSET_S;
    return pix_s > thr_s;
  endfunction

  // Foreground count never exceeds the pixel count of one pass.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt >= N_CNT) ? N_CNT : cnt + 1'b1;
  endfunction

  state_t              state_q, state_d;
  logic [PW-1:0]       pos_q, pos_d;
  logic                drain_q, drain_d;
  logic                vld_p1_q, vld_p1_d;
  logic [PW-1:0]       addr_p1_q, addr_p1_d;
  logic                wren_p2_q, wren_p2_d;
  logic [DATA_W-1:0]   data_p2_q, data_p2_d;
  logic [PW-1:0]       addr_p2_q, addr_p2_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                busy_q, busy_d;
  logic                finished_q, finished_d;

  // Next-state logic for the sequencer, address counter and both pipeline stages.
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    drain_d    = drain_q;
    count_d    = count_q;
    data_p2_d  = data_p2_q;
    addr_p2_d  = addr_p2_q;

    // Stage 0 -> 1: the address issued now pairs with memory data next cycle.
    vld_p1_d   = (state_q == S_RUN);
    addr_p1_d  = pos_q;

    // Stage 1 -> 2: memory data is valid; register the binary result.
    wren_p2_d  = vld_p1_q;
    if (vld_p1_q) begin
      addr_p2_d = addr_p1_q;
      if (is_fg(iImageData, iMeanData) ^ INV_B) begin
        data_p2_d = 8'hFF;
        count_d   = sat_inc(count_q);
      end else begin
        data_p2_d = 8'h00;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        pos_d = '0;
        if (start) begin
          state_d = S_RUN;
          count_d = '0;
        end
      end
      S_RUN: begin
        if (pos_q == LAST_POS) begin
          state_d = S_DRAIN;
          pos_d   = '0;
          drain_d = 1'b0;
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end
      S_DRAIN: begin
        pos_d   = '0;
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = S_DONE;
          drain_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
    finished_d = (state_d == S_DONE);
  end

  // Control state and registered outputs; reset aborts a pass immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pos_q      <= '0;
      drain_q    <= 1'b0;
      vld_p1_q   <= 1'b0;
      wren_p2_q  <= 1'b0;
      data_p2_q  <= '0;
      addr_p2_q  <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      drain_q    <= drain_d;
      vld_p1_q   <= vld_p1_d;
      wren_p2_q  <= wren_p2_d;
      data_p2_q  <= data_p2_d;
      addr_p2_q  <= addr_p2_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
    end
  end

  // Stage-1 address delay; qualified by vld_p1_q so it needs no reset.
  always_ff @(posedge clock) begin
    addr_p1_q <= addr_p1_d;
  end

  assign oReadCol         = pos_q[WIDTH_BITS-1:0];
  assign oReadRow         = pos_q[PW-1:WIDTH_BITS];
  assign oResultCol       = addr_p2_q[WIDTH_BITS-1:0];
  assign oResultRow       = addr_p2_q[PW-1:WIDTH_BITS];
  assign oResultData      = data_p2_q;
  assign oResultWren      = wren_p2_q;
  assign oForegroundCount = count_q;
  assign busy             = busy_q;
  assign finished         = finished_q;

endmodule

// File: tb/tb_adaptive_threshold.sv
// Bench for adaptive_threshold on a 4x4 image: two instances (normal and
// inverted polarity) share stimulus, each with its own 1-cycle sync RAM reads.
module tb_adaptive_threshold;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  always #5 clock = ~clock;

  logic [1:0] rc0, rr0, oc0, or0, rc1, rr1, oc1, or1;
  logic [7:0] img_rd0, mean_rd0, img_rd1, mean_rd1, data0, data1;
  logic       wren0, wren1, busy0, busy1, fin0, fin1;
  logic [4:0] cnt0, cnt1;

  int img_mem[16];
  int mean_mem[16];
  int n_checks = 0;
  int n_pass   = 0;

  adaptive_threshold #(.WIDTH_BITS(2), .HEIGHT_BITS(2), .OFFSET(8), .INVERT(0)) dut0 (
    .clock(clock), .reset(reset), .start(start),
    .oReadCol(rc0), .oReadRow(rr0), .iImageData(img_rd0), .iMeanData(mean_rd0),
    .oResultCol(oc0), .oResultRow(or0), .oResultData(data0), .oResultWren(wren0),
    .oForegroundCount(cnt0), .busy(busy0), .finished(fin0));

  adaptive_threshold #(.WIDTH_BITS(2), .HEIGHT_BITS(2), .OFFSET(8), .INVERT(1)) dut1 (
    .clock(clock), .reset(reset), .start(start),
    .oReadCol(rc1), .oReadRow(rr1), .iImageData(img_rd1), .iMeanData(mean_rd1),
    .oResultCol(oc1), .oResultRow(or1), .oResultData(data1), .oResultWren(wren1),
    .oForegroundCount(cnt1), .busy(busy1), .finished(fin1));

  // Synchronous-read memories: data appears one clock after the address.
  always @(posedge clock) begin
    img_rd0  <= 8'(img_mem[{rr0, rc0}]);
    mean_rd0 <= 8'(mean_mem[{rr0, rc0}]);
    img_rd1  <= 8'(img_mem[{rr1, rc1}]);
    mean_rd1 <= 8'(mean_mem[{rr1, rc1}]);
  end

  // Reference: pixel is foreground when it exceeds (mean - 8) as plain integers.
  function automatic int exp_pix(input int img, input int mean, input int inv);
    int fg;
    fg = (img > (mean - 8)) ? 1 : 0;
    return ((fg ^ inv) != 0) ? 255 : 0;
  endfunction

  function automatic int exp_count(input int upto, input int inv);
    int n;
    n = 0;
    for (int p = 0; p <= upto && p < 16; p++)
      if (exp_pix(img_mem[p], mean_mem[p], inv) == 255) n++;
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic get_outs(input int d, output int rd_addr, output int wr_addr,
                          output int data, output int wren, output int cnt,
                          output int bsy, output int fin);
    if (d == 0) begin
      rd_addr = int'({rr0, rc0}); wr_addr = int'({or0, oc0}); data = int'(data0);
      wren = int'(wren0); cnt = int'(cnt0); bsy = int'(busy0); fin = int'(fin0);
    end else begin
      rd_addr = int'({rr1, rc1}); wr_addr = int'({or1, oc1}); data = int'(data1);
      wren = int'(wren1); cnt = int'(cnt1); bsy = int'(busy1); fin = int'(fin1);
    end
  endtask

  // Cycle c counts from the first address issued after start.
  task automatic check_cycle(input int c, input int d);
    int rd_addr, wr_addr, data, wren, cnt, bsy, fin, p;
    string tag;
    get_outs(d, rd_addr, wr_addr, data, wren, cnt, bsy, fin);
    tag = $sformatf("d%0d_c%0d", d, c);
    chk({tag, "_wren"}, wren, (c >= 2 && c <= 17) ? 1 : 0);
    chk({tag, "_busy"}, bsy, (c <= 17) ? 1 : 0);
    chk({tag, "_finished"}, fin, (c >= 18) ? 1 : 0);
    chk({tag, "_rdaddr"}, rd_addr, (c < 16) ? c : 0);
    chk({tag, "_count"}, cnt, (c >= 2) ? exp_count(c - 2, d) : 0);
    if (c >= 2) begin
      p = (c <= 17) ? c - 2 : 15;
      chk({tag, "_wraddr"}, wr_addr, p);
      chk({tag, "_data"}, data, exp_pix(img_mem[p], mean_mem[p], d));
    end
  endtask

  task automatic check_zero(input string tag);
    int rd_addr, wr_addr, data, wren, cnt, bsy, fin;
    for (int d = 0; d < 2; d++) begin
      get_outs(d, rd_addr, wr_addr, data, wren, cnt, bsy, fin);
      chk($sformatf("%s_d%0d_alloutputs", tag, d),
          rd_addr + wr_addr + data + wren + cnt + bsy + fin, 0);
    end
  endtask

  // One pass; optional start pulse while busy, optional reset at a given cycle.
  task automatic run_pass(input int busy_start_at, input int abort_at);
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    for (int c = 0; c <= 19; c++) begin
      if (c > 0) @(negedge clock);
      check_cycle(c, 0);
      check_cycle(c, 1);
      start = (c == busy_start_at) ? 1'b1 : 1'b0;
      if (c == abort_at) begin
        reset = 1'b1;
        @(negedge clock);
        check_zero("abort");
        reset = 1'b0;
        repeat (3) begin
          @(negedge clock);
          check_zero("after_abort");
        end
        return;
      end
    end
  endtask

  task automatic fill_const(input int img, input int mean);
    for (int p = 0; p < 16; p++) begin
      img_mem[p]  = img;
      mean_mem[p] = mean;
    end
  endtask

  task automatic fill_random();
    int m;
    for (int p = 0; p < 16; p++) begin
      img_mem[p] = int'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) m = int'($urandom_range(0, 255));
      else m = img_mem[p] + int'($urandom_range(6, 10));
      mean_mem[p] = (m > 255) ? 255 : m;
    end
  endtask

  initial begin
    fill_const(0, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_zero("in_reset");
    reset = 1'b0;
    @(negedge clock);
    check_zero("idle");

    chk("model_fg_basic", exp_pix(100, 100, 0), 255);
    chk("model_equal_is_bg", exp_pix(100, 108, 0), 0);
    chk("model_negative_thr", exp_pix(0, 5, 0), 255);
    chk("model_negative_thr_inv", exp_pix(0, 5, 1), 0);

    fill_const(100, 100);
    run_pass(-1, -1);
    chk("all_fg_final_count", int'(cnt0), 16);

    fill_const(100, 108);
    run_pass(-1, -1);
    chk("equality_final_count", int'(cnt0), 0);

    fill_const(0, 5);
    run_pass(-1, -1);
    chk("underflow_final_count", int'(cnt0), 16);
    chk("underflow_inv_final_count", int'(cnt1), 0);

    for (int p = 0; p < 16; p++) begin
      img_mem[p]  = (((p / 4) + (p % 4)) % 2 == 1) ? 255 : 0;
      mean_mem[p] = 128;
    end
    run_pass(-1, -1);
    chk("checker_final_count", int'(cnt0), 8);

    fill_random();
    run_pass(-1, 7);
    fill_random();
    run_pass(-1, -1);
    fill_random();
    run_pass(5, -1);
    fill_random();
    run_pass(-1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
